xor_share_sched: RTL and testbench

Round-robin scheduler that time-shares a single 1-bit CMOS XOR cell among NREQ requesters. Each requester presents a WIDTH-bit operand pair. The block grants one requester, streams the pair LSB-first through the XOR cell over WIDTH cycles, and returns the bitwise XOR word with its parity. It sits between the requesting datapath blocks and the shared XOR cell and replaces a per-requester array of XOR cells.

---
 rtl/xor_sched_pkg.sv | 33 +++
 rtl/xor_cell.sv | 10 +
 rtl/xor_share_sched.sv | 117 +++++++++++
 tb/tb_xor_share_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_sched_pkg.sv
// rtl/xor_sched_pkg.sv - shared types and round-robin pick for the XOR-cell scheduler
package xor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Upper bound on requesters the pick function can handle; callers zero-extend.
  localparam int MAX_REQ = 32;

  // One-hot grant of the first set bit of valid, searching upward from ptr, mod n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [5:0] n,
                                                 input logic [5:0] ptr);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [5:0]         idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + 6'(k);
      if (idx >= n) idx = idx - n;
      if ((6'(k) < n) && !found && valid[idx[4:0]]) begin
        grant[idx[4:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/xor_cell.sv
// rtl/xor_cell.sv - the single shared 1-bit XOR cell being time-shared
module xor_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_share_sched.sv
// rtl/xor_share_sched.sv - round-robin scheduler streaming operand pairs LSB-first through one XOR cell
module xor_share_sched
  import xor_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_parity,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               parity_acc;
  logic [CW-1:0]      cnt;
  logic [IDW-1:0]     rr_ptr, gidx;
  logic [MAX_REQ-1:0] valid_ext, pick;
  logic [NREQ-1:0]    grant;
  logic               any_grant, cell_y, load, shift_en;

  assign valid_ext = MAX_REQ'(req_valid);
  assign pick      = rr_pick(valid_ext, 6'(NREQ), 6'(rr_ptr));
  assign grant     = pick[NREQ-1:0];
  assign any_grant = |pick;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = IDW'(i);
    end
  end

  xor_cell u_cell (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .y (cell_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rst_n gates the grant so req_ready drops the instant reset asserts.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_grant && rst_n) begin
          load      = 1'b1;
          req_ready = grant;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      parity_acc <= 1'b0;
      cnt        <= '0;
      rsp_id     <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      a_sr       <= req_a[gidx*WIDTH +: WIDTH];
      b_sr       <= req_b[gidx*WIDTH +: WIDTH];
      res_sr     <= '0;
      parity_acc <= 1'b0;
      cnt        <= '0;
      rsp_id     <= gidx;
      rr_ptr     <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    end else if (shift_en) begin
      // Result fills from the MSB so bit 0 lands at the LSB after WIDTH shifts.
      a_sr       <= a_sr >> 1;
      b_sr       <= b_sr >> 1;
      res_sr     <= {cell_y, res_sr[WIDTH-1:1]};
      parity_acc <= parity_acc ^ cell_y;
      cnt        <= cnt + 1'b1;
    end
  end

  assign rsp_data   = res_sr;
  assign rsp_parity = parity_acc;

endmodule

// File: tb/tb_xor_share_sched.sv
// tb/tb_xor_share_sched.sv - scoreboard bench for xor_share_sched with a cycle-level reference scheduler
module tb_xor_share_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_parity;
  logic                  busy;

  xor_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_parity (rsp_parity),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    logic             par;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference scheduler: a cycle count since grant and a rotating pointer.
  int mptr = 0;
  int mcnt = -1;
  always @(negedge clk) begin
    int               g;
    int               exp_ready, exp_valid, exp_busy;
    logic [WIDTH-1:0] a, b;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_parity", 32'(rsp_parity), 0);
      mptr = 0;
      mcnt = -1;
      exp_q.delete();
    end else begin
      exp_ready = 0;
      exp_valid = 0;
      exp_busy  = 0;
      if (mcnt < 0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
        end
        if (g >= 0) begin
          exp_ready = 1 << g;
          a = req_a[g*WIDTH +: WIDTH];
          b = req_b[g*WIDTH +: WIDTH];
          exp_q.push_back('{g, a ^ b, ^(a ^ b)});
          mptr = (g + 1) % NREQ;
          mcnt = 1;
        end
      end else if (mcnt <= WIDTH) begin
        exp_busy = 1;
        mcnt++;
      end else begin
        exp_busy  = 1;
        exp_valid = 1;
        if (rsp_ready) mcnt = -1;
      end
      chk("req_ready", 32'(req_ready), exp_ready);
      chk("rsp_valid", 32'(rsp_valid), exp_valid);
      chk("busy", 32'(busy), exp_busy);
    end
  end

  // Response monitor: compares every cycle rsp_valid is up, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected actual=%0h required=none at %0t", rsp_data, $time);
      end else begin
        chk("rsp_id", 32'(rsp_id), exp_q[0].id);
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        chk("rsp_parity", 32'(rsp_parity), 32'(exp_q[0].par));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_op(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[r*WIDTH +: WIDTH] = a;
    req_b[r*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_grant(input int r);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1;
    end
    chk($sformatf("grant_seen_%0d", r), 32'(ok), 1);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) ok = 1;
    end
    chk("idle_reached", 32'(ok), 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Single request; operands change right after the grant.
    set_op(0, 8'hA5, 8'h0F);
    req_valid = 4'b0001;
    wait_grant(0);
    req_valid = '0;
    set_op(0, 8'h3C, 8'hC3);
    wait_idle();

    set_op(2, 8'hFF, 8'h00);
    req_valid = 4'b0100;
    wait_grant(2);
    req_valid = '0;
    wait_idle();

    set_op(3, 8'h01, 8'h00);
    req_valid = 4'b1000;
    wait_grant(3);
    req_valid = '0;
    wait_idle();

    // All requesters valid continuously.
    req_valid = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      req_a = $urandom;
      req_b = $urandom;
      step(1);
    end
    req_valid = '0;
    wait_idle();

    // Backpressure in DONE with others waiting.
    rsp_ready = 1'b0;
    set_op(0, 8'h5A, 8'h96);
    req_valid = 4'b0001;
    wait_grant(0);
    req_valid = 4'b0110;
    for (int i = 0; i < 40 && !rsp_valid; i++) step(1);
    step(5);
    rsp_ready = 1'b1;
    wait_grant(1);
    req_valid = '0;
    wait_idle();

    // Reset in the fourth SHIFT cycle.
    set_op(1, 8'h77, 8'h11);
    req_valid = 4'b0010;
    wait_grant(1);
    req_valid = '0;
    step(3);
    rst_n     = 1'b0;
    req_valid = 4'b0101;
    step(2);
    rst_n = 1'b1;
    wait_grant(0);
    req_valid = '0;
    wait_idle();

    // Pointer after granting 1 favours 0 over 1.
    req_valid = 4'b0010;
    wait_grant(1);
    req_valid = 4'b0011;
    wait_grant(0);
    req_valid = '0;
    wait_idle();

    // Random traffic including drops before grant and backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ready = ($urandom % 4) != 0;
      step(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
